pipe_addsub: RTL and testbench
==============================

// Module: pipe_addsub
// PURPOSE
//  Parametrised, pipelined integer add/subtract unit for the EduRISC-V datapath; the successor of the
//  single-cycle combinational adder. Splits the WIDTH-bit carry chain into STAGES chunks, one per
//  pipeline stage, for higher Fmax. Adds SUB/carry-in modes, C/V/Z flags, a pass-through tag and a
//  valid/ready handshake. Sits between issue and writeback; throughput 1 op/cycle, latency STAGES.
// PARAMETERS
//  WIDTH   XLEN (32)  operand/result width; must be divisible by STAGES
//  STAGES  2          pipeline stages = carry-chain chunks, legal 1..4; CW = WIDTH/STAGES bits per chunk
//  TAG_W   5          width of opaque tag (e.g. rd index) carried alongside the op
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       operation presented
//  in_ready   out  1       unit accepts operation this cycle
//  in_op      in   2       00 ADD A+B; 01 SUB A+~B+1; 10 ADC A+B+cin; 11 SBC A+~B+cin
//  in_cin     in   1       carry-in, used only by ADC/SBC
//  in_a       in   WIDTH   operand A
//  in_b       in   WIDTH   operand B
//  in_tag     in   TAG_W   tag, returned unchanged with result
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_f      out  WIDTH   result, modulo 2^WIDTH
//  out_c      out  1       carry-out of bit WIDTH-1 (SUB: 1 = no borrow)
//  out_v      out  1       signed overflow: (A[msb]==B'[msb]) && (F[msb]!=A[msb]), B' = B or ~B
//  out_z      out  1       F == 0
//  out_tag    out  TAG_W   tag of the op in out_f
// BEHAVIOUR
//  - Reset: all stage valid bits 0; out_valid=0, out_f=0, out_c=0, out_v=0, out_z=0, out_tag=0.
//    Reset mid-operation discards every in-flight op; no partial result is ever emitted.
//  - Stage-0 effective carry-in: ADD 0, SUB 1, ADC/SBC in_cin. B' = ~B for SUB/SBC, else B.
//  - Stage k (0..STAGES-1) adds chunk k: {c,s} = A[k*CW+:CW] + B'[k*CW+:CW] + carry_k, CW+1-bit sum;
//    registers s into result slice k and c as carry for stage k+1. Upper unconsumed A/B' chunks,
//    tag and running zero-AND are skew-registered with the op. No chunk adder spans two stages.
//  - Final stage also registers out_c (its carry), out_v (from msb of A, B', F) and
//    out_z = zero_so_far && (chunk sum == 0).
//  - Handshake: advance = !out_valid || out_ready; in_ready = advance (combinational from out_valid,
//    out_ready only; never from in_valid). Op accepted iff in_valid && in_ready.
//  - When advance=1 every stage shifts by one (bubbles included); when 0 all stages hold, outputs
//    stable. Result for op accepted at edge n appears at edge n+STAGES-1 if never stalled, i.e.
//    out_valid seen in cycle n+STAGES-1 after accept cycle n (STAGES=1: next cycle).
//  - Back-to-back accepts with out_ready=1 give one result per cycle, in order, no bubbles.
//  - Simultaneous out handshake and in accept in same cycle allowed (full throughput while full).
//  - Stage capacity is STAGES ops; no internal skid, so in_ready drops the cycle out is stalled.
//  - Inputs ignored when in_valid=0; X on in_a/in_b with in_valid=0 must not propagate to flags.
//  - STAGES=1 is legal: plain registered adder with flags.
// TESTING
//  1 WIDTH=32,STAGES=2: ADD 0x0000FFFF+0x00000001 -> out_f=0x00010000,c=0,v=0,z=0, 2 cycles later
//    (cross-chunk carry).
//  2 SUB 5-5 -> f=0,c=1,z=1,v=0; SUB 0-1 -> f=0xFFFFFFFF,c=0,v=0; ADD 0x7FFFFFFF+1 -> f=0x80000000,v=1.
//  3 ADC 0xFFFFFFFF+0+cin=1 -> f=0,c=1,z=1; SBC 10-3 with cin=0 -> f=6,c=1.
//  4 Stream 8 ops, tags 0..7, out_ready=1 -> 8 results on consecutive cycles, tags in order.
//  5 Hold out_ready=0 with pipe full -> in_ready=0, outputs stable; release -> no op lost/duplicated.
//  6 Assert rst with 2 ops in flight -> out_valid=0 next cycle, outputs 0, no stale result; repeat
//    tests 1-2 for STAGES=1 and STAGES=4.

Source files
------------

// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined add/subtract unit with C/V/Z flags, tag and valid/ready
// Carry chain split into STAGES chunks; stage k adds chunk k and passes the carry forward.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = WIDTH / STAGES;

  logic             w_adv;
  logic [WIDTH-1:0] w_a0;
  logic [WIDTH-1:0] w_b0;
  logic             w_c0;
  logic [TAG_W-1:0] w_tag0;
  logic             w_v_n;

  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_f   [STAGES];
  logic             r_c   [STAGES];
  logic             r_z   [STAGES];
  logic [TAG_W-1:0] r_tag [STAGES];
  logic             r_v;

  logic             w_vld_n [STAGES];
  logic [WIDTH-1:0] w_a_n   [STAGES];
  logic [WIDTH-1:0] w_b_n   [STAGES];
  logic [WIDTH-1:0] w_f_n   [STAGES];
  logic             w_c_n   [STAGES];
  logic             w_z_n   [STAGES];
  logic [TAG_W-1:0] w_tag_n [STAGES];

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Idle inputs are forced to zero so junk or X never reaches the pipeline flags.
  always_comb begin
    w_a0   = in_valid ? in_a : '0;
    w_b0   = '0;
    if (in_valid) w_b0 = in_op[0] ? ~in_b : in_b;
    w_c0   = in_valid && (in_op[1] ? in_cin : in_op[0]);
    w_tag0 = in_valid ? in_tag : '0;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_vld_i;
    logic [WIDTH-1:0] w_a_i;
    logic [WIDTH-1:0] w_b_i;
    logic [WIDTH-1:0] w_f_i;
    logic [WIDTH-1:0] w_f_o;
    logic             w_c_i;
    logic             w_z_i;
    logic [TAG_W-1:0] w_tag_i;
    logic [CW:0]      w_sum;

    if (k == 0) begin : g_first
      assign w_vld_i = in_valid;
      assign w_a_i   = w_a0;
      assign w_b_i   = w_b0;
      assign w_f_i   = '0;
      assign w_c_i   = w_c0;
      assign w_z_i   = 1'b1;
      assign w_tag_i = w_tag0;
    end else begin : g_next
      assign w_vld_i = r_vld[k-1];
      assign w_a_i   = r_a[k-1];
      assign w_b_i   = r_b[k-1];
      assign w_f_i   = r_f[k-1];
      assign w_c_i   = r_c[k-1];
      assign w_z_i   = r_z[k-1];
      assign w_tag_i = r_tag[k-1];
    end

    assign w_sum = {1'b0, w_a_i[k*CW +: CW]} + {1'b0, w_b_i[k*CW +: CW]} + {{CW{1'b0}}, w_c_i};

    always_comb begin
      w_f_o              = w_f_i;
      w_f_o[k*CW +: CW]  = w_sum[CW-1:0];
    end

    assign w_vld_n[k] = w_vld_i;
    assign w_a_n[k]   = w_a_i;
    assign w_b_n[k]   = w_b_i;
    assign w_f_n[k]   = w_f_o;
    assign w_c_n[k]   = w_sum[CW];
    assign w_z_n[k]   = w_z_i && (w_sum[CW-1:0] == '0);
    assign w_tag_n[k] = w_tag_i;

    if (k == STAGES - 1) begin : g_last
      assign w_v_n = (w_a_i[WIDTH-1] == w_b_i[WIDTH-1]) && (w_f_o[WIDTH-1] != w_a_i[WIDTH-1]);
    end
  end

  // All stages shift together, bubbles included, so order and latency stay fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i] <= 1'b0;
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_f[i]   <= '0;
        r_c[i]   <= 1'b0;
        r_z[i]   <= 1'b0;
        r_tag[i] <= '0;
      end
      r_v <= 1'b0;
    end else if (w_adv) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i] <= w_vld_n[i];
        r_a[i]   <= w_a_n[i];
        r_b[i]   <= w_b_n[i];
        r_f[i]   <= w_f_n[i];
        r_c[i]   <= w_c_n[i];
        r_z[i]   <= w_z_n[i];
        r_tag[i] <= w_tag_n[i];
      end
      r_v <= w_v_n;
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign out_f     = r_f[STAGES-1];
  assign out_c     = r_c[STAGES-1];
  assign out_v     = r_v;
  assign out_z     = r_z[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - directed self-checking bench for pipe_addsub at STAGES 2, 1 and 4
module tb_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld  [3];
  logic        irdy [3];
  logic        ordy [3];
  logic        cin  [3];
  logic        ov   [3];
  logic        oc   [3];
  logic        ovf  [3];
  logic        oz   [3];
  logic [1:0]  op   [3];
  logic [31:0] a    [3];
  logic [31:0] b    [3];
  logic [31:0] f    [3];
  logic [4:0]  tg   [3];
  logic [4:0]  otg  [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipe_addsub #(
      .WIDTH (32),
      .STAGES(g == 0 ? 2 : (g == 1 ? 1 : 4)),
      .TAG_W (5)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (vld[g]),
      .in_ready (irdy[g]),
      .in_op    (op[g]),
      .in_cin   (cin[g]),
      .in_a     (a[g]),
      .in_b     (b[g]),
      .in_tag   (tg[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out_f    (f[g]),
      .out_c    (oc[g]),
      .out_v    (ovf[g]),
      .out_z    (oz[g]),
      .out_tag  (otg[g])
    );
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] f;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t tbl [9];

  function automatic int stg(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  task automatic send_wait(input int d, input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                           input logic xc, input logic [4:0] t, output int lat);
    vld[d] = 1'b1; op[d] = o; a[d] = xa; b[d] = xb; cin[d] = xc; tg[d] = t;
    @(posedge clk); #1;
    vld[d] = 1'b0; op[d] = 2'b11; a[d] = 32'hDEADBEEF; b[d] = 32'h12345678; cin[d] = 1'b1; tg[d] = 5'h1F;
    lat = 1;
    while (!ov[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b1; ordy[d] = 1'b1; op[d] = 2'b00; cin[d] = 1'b0;
      a[d] = 32'hFFFFFFFF; b[d] = 32'h00000001; tg[d] = 5'd7;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) vld[d] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || f[d] !== 32'h0 || oc[d] !== 1'b0 || ovf[d] !== 1'b0 || oz[d] !== 1'b0 || otg[d] !== 5'd0) begin
        errors++;
        $display("FAIL reset_state s%0d got valid=%b f=%h c=%b v=%b z=%b tag=%0d exp all zero",
                 stg(d), ov[d], f[d], oc[d], ovf[d], oz[d], otg[d]);
      end
      checks++;
      if (irdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready s%0d got %b exp 1", stg(d), irdy[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_arith(input int d);
    int lat;
    for (int i = 0; i < 9; i++) begin
      send_wait(d, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, 5'(i + 3), lat);
      checks++;
      if (lat !== stg(d)) begin
        errors++;
        $display("FAIL arith_latency s%0d vec%0d got %0d exp %0d", stg(d), i, lat, stg(d));
      end
      checks++;
      if (f[d] !== tbl[i].f) begin
        errors++;
        $display("FAIL arith_f s%0d vec%0d got %h exp %h", stg(d), i, f[d], tbl[i].f);
      end
      checks++;
      if (oc[d] !== tbl[i].c || ovf[d] !== tbl[i].v || oz[d] !== tbl[i].z) begin
        errors++;
        $display("FAIL arith_flags s%0d vec%0d got c=%b v=%b z=%b exp c=%b v=%b z=%b",
                 stg(d), i, oc[d], ovf[d], oz[d], tbl[i].c, tbl[i].v, tbl[i].z);
      end
      checks++;
      if (otg[d] !== 5'(i + 3)) begin
        errors++;
        $display("FAIL arith_tag s%0d vec%0d got %0d exp %0d", stg(d), i, otg[d], i + 3);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [4:0]  got_t [8];
    logic [31:0] got_f [8];
    int          got_c [8];
    int          n;
    int          bad_rdy;
    n = 0; bad_rdy = 0;
    ordy[0] = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      vld[0] = (cyc < 8);
      op[0]  = 2'b00; cin[0] = 1'b1;
      a[0]   = 32'h0000FFFF + 32'(cyc);
      b[0]   = (32'(cyc) << 16) | 32'h1;
      tg[0]  = 5'(cyc);
      #1;
      if (cyc < 8 && irdy[0] !== 1'b1) bad_rdy++;
      @(posedge clk); #1;
      if (ov[0] && n < 8) begin
        got_t[n] = otg[0]; got_f[n] = f[0]; got_c[n] = cyc; n++;
      end
    end
    vld[0] = 1'b0;
    checks++;
    if (bad_rdy != 0) begin
      errors++;
      $display("FAIL stream_in_ready got %0d low cycles exp 0", bad_rdy);
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL stream_count got %0d exp 8", n);
    end
    checks++;
    if (n > 0 && got_c[0] != 1) begin
      errors++;
      $display("FAIL stream_first_cycle got %0d exp 1", got_c[0]);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_t[i] !== 5'(i) || got_f[i] !== (32'h0000FFFF + 32'(i)) + ((32'(i) << 16) | 32'h1) || got_c[i] != got_c[0] + i) begin
        errors++;
        $display("FAIL stream_result%0d got tag=%0d f=%h cyc=%0d exp tag=%0d f=%h cyc=%0d", i, got_t[i], got_f[i],
                 got_c[i], i, (32'h0000FFFF + 32'(i)) + ((32'(i) << 16) | 32'h1), got_c[0] + i);
      end
    end
  endtask

  task automatic test_stall;
    logic [4:0]  got_t [6];
    logic [31:0] got_f [6];
    int          ip;
    int          n;
    logic        acc;
    ip = 0; n = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      ordy[0] = (cyc >= 6);
      vld[0]  = (ip < 3);
      op[0]   = 2'b00; cin[0] = 1'b0;
      a[0]    = 32'(ip + 10) * 32'h01010101;
      b[0]    = 32'h00FF00FF;
      tg[0]   = 5'(ip + 10);
      #1;
      if (cyc >= 2 && cyc < 6) begin
        checks++;
        if (irdy[0] !== 1'b0 || ov[0] !== 1'b1 || otg[0] !== 5'd10 || f[0] !== 32'h0A0A0A0A + 32'h00FF00FF) begin
          errors++;
          $display("FAIL stall_hold cyc%0d got in_ready=%b valid=%b tag=%0d f=%h exp 0 1 10 %h",
                   cyc, irdy[0], ov[0], otg[0], f[0], 32'h0A0A0A0A + 32'h00FF00FF);
        end
      end
      acc = vld[0] && irdy[0];
      if (ov[0] && ordy[0] && n < 6) begin
        got_t[n] = otg[0]; got_f[n] = f[0]; n++;
      end
      @(posedge clk); #1;
      if (acc) ip++;
    end
    vld[0] = 1'b0; ordy[0] = 1'b1;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL stall_count got %0d exp 3", n);
    end
    for (int i = 0; i < n && i < 3; i++) begin
      checks++;
      if (got_t[i] !== 5'(i + 10) || got_f[i] !== 32'(i + 10) * 32'h01010101 + 32'h00FF00FF) begin
        errors++;
        $display("FAIL stall_result%0d got tag=%0d f=%h exp tag=%0d f=%h", i, got_t[i], got_f[i],
                 i + 10, 32'(i + 10) * 32'h01010101 + 32'h00FF00FF);
      end
    end
  endtask

  task automatic test_reset_inflight;
    int stale;
    stale = 0;
    ordy[0] = 1'b1;
    vld[0] = 1'b1; op[0] = 2'b00; cin[0] = 1'b0; a[0] = 32'h11; b[0] = 32'h22; tg[0] = 5'd20;
    @(posedge clk); #1;
    a[0] = 32'h33; b[0] = 32'h44; tg[0] = 5'd21;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b1 || otg[0] !== 5'd20) begin
      errors++;
      $display("FAIL inflight_pre got valid=%b tag=%0d exp 1 20", ov[0], otg[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || f[0] !== 32'h0 || oc[0] !== 1'b0 || ovf[0] !== 1'b0 || oz[0] !== 1'b0 || otg[0] !== 5'd0) begin
      errors++;
      $display("FAIL inflight_reset got valid=%b f=%h c=%b v=%b z=%b tag=%0d exp all zero",
               ov[0], f[0], oc[0], ovf[0], oz[0], otg[0]);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ov[0] !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL inflight_stale got %0d valid cycles exp 0", stale);
    end
  endtask

  initial begin
    tbl[0] = '{2'b00, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'b01, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{2'b01, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{2'b10, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{2'b11, 32'h0000000A, 32'h00000003, 1'b0, 32'h00000006, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{2'b00, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{2'b01, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{2'b10, 32'h0000FFFF, 32'hFFFF0000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};

    test_reset();
    for (int d = 0; d < 3; d++) test_arith(d);
    test_back_to_back();
    test_stall();
    test_reset_inflight();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
